// File: rtl/tm1638_chain_ctrl.sv
// TM1638 controller for N_BOARDS modules on a shared clk/dio bus, one strobe each.
// Define TM1638_AUTO_REFRESH_EN to add a free-running internal refresh request.
module tm1638_chain_ctrl #(
    parameter int N_BOARDS       = 2,
    parameter int HALF_DIV       = 5,
    parameter int STB_GAP        = 2,
    parameter int RD_WAIT        = 2,
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    display_on,
    input  logic [2:0]              display_level,
    input  logic [N_BOARDS*128-1:0] seg_data,
    output logic                    busy,
    output logic                    done,
    output logic [N_BOARDS*32-1:0]  keys,
    output logic                    keys_valid,
    output logic                    tm_clk,
    output logic [N_BOARDS-1:0]     tm_stb,
    output logic                    tm_dio_o,
    output logic                    tm_dio_oe,
    input  logic                    tm_dio_i
);
    localparam int BW     = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1;
    localparam int CW     = 24;
    localparam int GAP_N  = (STB_GAP > 0) ? STB_GAP * 2 * HALF_DIV : 1;
    localparam int WAIT_N = (RD_WAIT > 0) ? RD_WAIT * 2 * HALF_DIV : 1;

    typedef enum logic [3:0] {
        IDLE, W_MODE, W_ADDR, W_DATA, CTRL,
        R_CMD, R_WAIT, R_DATA, GAP, NEXT
    } state_t;

    state_t                 r_state;
    state_t                 r_ret;
    logic [BW-1:0]          r_board;
    logic [CW-1:0]          r_cnt;
    logic [4:0]             r_bit;
    logic [3:0]             r_byte;
    logic [7:0]             r_tx;
    logic [31:0]            r_rx;
    logic [127:0]           r_seg;
    logic                   r_on;
    logic [2:0]             r_lvl;
    logic                   r_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_clk;
    logic                   r_dio;
    logic                   r_oe;
    logic [N_BOARDS-1:0]    r_stb;
    logic [N_BOARDS*32-1:0] r_shadow;
    logic [N_BOARDS*32-1:0] r_keys;

    logic                   w_start;
    logic                   w_go;
    logic                   w_half_end;
    logic                   w_last_bit;
    logic                   w_last_board;
    logic [BW-1:0]          w_nb;
    logic [127:0]           w_seg_in;
    logic [7:0]             w_ctrl;
    logic [7:0]             w_ret_byte;
    logic [7:0]             w_next_seg;
    logic [N_BOARDS-1:0]    w_stb_on;

`ifdef TM1638_AUTO_REFRESH_EN
    logic [31:0] r_ar;
    logic        r_auto;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ar   <= '0;
            r_auto <= 1'b0;
        end else begin
            r_auto <= (r_ar == 32'(REFRESH_CYCLES - 1));
            r_ar   <= (r_ar == 32'(REFRESH_CYCLES - 1)) ? '0 : r_ar + 32'd1;
        end
    end

    assign w_start = start | r_auto;
`else
    assign w_start = start;
`endif

    assign w_last_board = (r_board == BW'(N_BOARDS - 1));
    assign w_nb         = (r_state == NEXT) ? r_board + BW'(1) : '0;
    assign w_go         = (r_state == IDLE && (w_start || r_pend)) ||
                          (r_state == NEXT && !w_last_board);
    assign w_seg_in     = seg_data[int'(w_nb) * 128 +: 128];
    assign w_stb_on     = ~(N_BOARDS'(1) << r_board);
    assign w_half_end   = (r_cnt == CW'(HALF_DIV - 1));
    assign w_last_bit   = (r_state == R_DATA) ? (r_bit == 5'd31) : (r_bit == 5'd7);
    assign w_ctrl       = r_on ? {5'b10001, r_lvl} : 8'h80;
    assign w_next_seg   = r_seg[int'(r_byte) * 8 + 8 +: 8];

    always_comb begin
        w_ret_byte = 8'h42;
        case (r_ret)
            W_ADDR:  w_ret_byte = 8'hC0;
            CTRL:    w_ret_byte = w_ctrl;
            default: w_ret_byte = 8'h42;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_ret    <= IDLE;
            r_board  <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_seg    <= '0;
            r_on     <= 1'b0;
            r_lvl    <= '0;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_clk    <= 1'b1;
            r_dio    <= 1'b1;
            r_oe     <= 1'b1;
            r_stb    <= '1;
            r_shadow <= '0;
            r_keys   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start && r_state != IDLE) r_pend <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_busy <= w_start || r_pend;
                    if (w_start || r_pend) r_pend <= 1'b0;
                end
                GAP: begin
                    if (r_cnt != CW'(GAP_N - 1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= r_ret;
                        if (r_ret != NEXT) begin
                            r_stb <= w_stb_on;
                            r_clk <= 1'b0;
                            r_tx  <= w_ret_byte;
                            r_dio <= w_ret_byte[0];
                            r_bit <= '0;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt != CW'(WAIT_N - 1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_clk   <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                NEXT: begin
                    if (w_last_board) begin
                        r_keys  <= r_shadow;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    if (!w_half_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!r_clk) begin
                        r_cnt <= '0;
                        r_clk <= 1'b1;
                        if (r_state == R_DATA) r_rx <= {tm_dio_i, r_rx[31:1]};
                    end else if (!w_last_bit) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 5'd1;
                        r_clk <= 1'b0;
                        if (r_state != R_DATA) r_dio <= r_tx[r_bit[2:0] + 3'd1];
                    end else begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        // Byte boundary: chain the next byte or close the transaction.
                        case (r_state)
                            W_ADDR: begin
                                r_state <= W_DATA;
                                r_byte  <= '0;
                                r_tx    <= r_seg[7:0];
                                r_dio   <= r_seg[0];
                                r_clk   <= 1'b0;
                            end
                            W_DATA: begin
                                if (r_byte != 4'd15) begin
                                    r_byte <= r_byte + 4'd1;
                                    r_tx   <= w_next_seg;
                                    r_dio  <= w_next_seg[0];
                                    r_clk  <= 1'b0;
                                end else begin
                                    r_stb   <= '1;
                                    r_ret   <= CTRL;
                                    r_state <= GAP;
                                end
                            end
                            R_CMD: begin
                                r_oe    <= 1'b0;
                                r_state <= R_WAIT;
                            end
                            R_DATA: begin
                                r_shadow[int'(r_board) * 32 +: 32] <= r_rx;
                                r_oe    <= 1'b1;
                                r_stb   <= '1;
                                r_ret   <= NEXT;
                                r_state <= GAP;
                            end
                            CTRL: begin
                                r_stb   <= '1;
                                r_ret   <= R_CMD;
                                r_state <= GAP;
                            end
                            default: begin
                                r_stb   <= '1;
                                r_ret   <= W_ADDR;
                                r_state <= GAP;
                            end
                        endcase
                    end
                end
            endcase
            if (w_go) begin
                r_board <= w_nb;
                r_seg   <= w_seg_in;
                r_on    <= display_on;
                r_lvl   <= display_level;
                r_state <= W_MODE;
                r_stb   <= ~(N_BOARDS'(1) << w_nb);
                r_clk   <= 1'b0;
                r_tx    <= 8'h40;
                r_dio   <= 1'b0;
                r_bit   <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_done;
    assign keys       = r_keys;
    assign tm_clk     = r_clk;
    assign tm_stb     = r_stb;
    assign tm_dio_o   = r_dio;
    assign tm_dio_oe  = r_oe;

endmodule

// File: tb/tb_tm1638_chain_ctrl.sv
// Bench for tm1638_chain_ctrl: bus decoder plus TM1638 board model, three boards.
`timescale 1ns/1ps
module tb_tm1638_chain_ctrl;
    localparam int NB = 3;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start = 1'b0;
    logic            display_on = 1'b1;
    logic [2:0]      display_level = 3'd0;
    logic [NB*128-1:0] seg_data = '0;
    logic            busy, done, keys_valid, tm_clk, tm_dio_o, tm_dio_oe;
    logic            tm_dio_i = 1'b1;
    logic [NB*32-1:0] keys;
    logic [NB-1:0]   tm_stb;

    int checks = 0;
    int errors = 0;

    tm1638_chain_ctrl #(
        .N_BOARDS(NB), .HALF_DIV(2), .STB_GAP(2),
        .RD_WAIT(2), .REFRESH_CYCLES(2000)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .display_on(display_on), .display_level(display_level),
        .seg_data(seg_data), .busy(busy), .done(done), .keys(keys),
        .keys_valid(keys_valid), .tm_clk(tm_clk), .tm_stb(tm_stb),
        .tm_dio_o(tm_dio_o), .tm_dio_oe(tm_dio_oe), .tm_dio_i(tm_dio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           board;
        int           nbits;
        logic [135:0] data;
        int           nrd;
    } txn_t;

    txn_t        got_q[$];
    txn_t        exp_q[$];
    txn_t        cur;
    logic [31:0] rd_word [NB];
    int          rd_idx = 0;
    int          viol = 0;
    int          done_cnt = 0;
    logic        p_clk = 1'b1;
    logic        p_dio = 1'b1;
    logic [NB-1:0] p_stb = '1;
    logic        p_rst = 1'b0;

    // Bus monitor and key-board model, one sample per clk on the falling edge.
    initial begin
        cur = '{board: 0, nbits: 0, data: '0, nrd: 0};
        forever begin
            @(negedge clk);
            if (n_rst && p_rst) begin
                if ($countones(~tm_stb) > 1) viol++;
                if (tm_stb != '1 && !busy) viol++;
                if (!tm_dio_oe && tm_stb == '1) viol++;
                if (tm_dio_o !== p_dio && !(p_clk && !tm_clk)) viol++;
                if (tm_clk !== p_clk && tm_stb == '1 && p_stb == '1) viol++;
                if (done !== keys_valid) viol++;
                if (done) done_cnt++;
                if (p_stb == '1 && tm_stb != '1) begin
                    for (int i = 0; i < NB; i++) if (!tm_stb[i]) cur.board = i;
                    cur.nbits = 0;
                    cur.data = '0;
                    cur.nrd = 0;
                    rd_idx = 0;
                end
                if (!p_clk && tm_clk && tm_stb != '1) begin
                    if (tm_dio_oe) begin
                        if (cur.nbits < 136) cur.data[cur.nbits] = tm_dio_o;
                        cur.nbits++;
                    end else begin
                        cur.nrd++;
                    end
                end
                if (p_stb != '1 && tm_stb == '1) got_q.push_back(cur);
                if (p_clk && !tm_clk && !tm_dio_oe && rd_idx < 32) begin
                    tm_dio_i = rd_word[cur.board][rd_idx];
                    rd_idx++;
                end
            end
            p_clk = tm_clk;
            p_dio = tm_dio_o;
            p_stb = tm_stb;
            p_rst = n_rst;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_board(input int b, input logic [127:0] s,
                                        input bit on, input logic [2:0] lvl);
        txn_t t;
        t.board = b;
        t.nrd = 0;
        t.nbits = 8;
        t.data = '0;
        t.data[7:0] = 8'h40;
        exp_q.push_back(t);
        t.data = '0;
        t.data[7:0] = 8'hC0;
        for (int k = 0; k < 16; k++) t.data[8 + 8*k +: 8] = s[8*k +: 8];
        t.nbits = 136;
        exp_q.push_back(t);
        t.data = '0;
        t.data[7:0] = on ? 8'h88 + {5'd0, lvl} : 8'h80;
        t.nbits = 8;
        exp_q.push_back(t);
        t.data = '0;
        t.data[7:0] = 8'h42;
        t.nrd = 32;
        exp_q.push_back(t);
    endfunction

    function automatic int txn_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) begin
            if (got_q[i].board != exp_q[i].board || got_q[i].nbits != exp_q[i].nbits ||
                got_q[i].data !== exp_q[i].data || got_q[i].nrd != exp_q[i].nrd)
                return i;
        end
        return -1;
    endfunction

    function automatic logic [NB*32-1:0] exp_keys();
        logic [NB*32-1:0] k;
        for (int b = 0; b < NB; b++) k[b*32 +: 32] = rd_word[b];
        return k;
    endfunction

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic rand_setup();
        for (int i = 0; i < NB*4; i++) seg_data[i*32 +: 32] = $urandom();
        for (int b = 0; b < NB; b++) rd_word[b] = $urandom();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || keys_valid !== 1'b0) begin errors++; $display("FAIL rst_done got %b%b want 00", done, keys_valid); end
        checks++; if (keys !== '0) begin errors++; $display("FAIL rst_keys got %h want 0", keys); end
        checks++; if (tm_clk !== 1'b1) begin errors++; $display("FAIL rst_clk got %b want 1", tm_clk); end
        checks++; if (tm_stb !== '1) begin errors++; $display("FAIL rst_stb got %b want 111", tm_stb); end
        checks++; if (tm_dio_o !== 1'b1 || tm_dio_oe !== 1'b1) begin errors++; $display("FAIL rst_dio got %b%b want 11", tm_dio_o, tm_dio_oe); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_refresh();
        bit ok;
        int d;
        rand_setup();
        seg_data[7:0] = 8'h3F;
        rd_word[0] = 32'h80100001;
        display_on = 1'b1;
        display_level = 3'd4;
        for (int b = 0; b < NB; b++) model_board(b, seg_data[b*128 +: 128], 1'b1, 3'd4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pre_busy got %b want 0", busy); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || tm_stb !== 3'b110) begin errors++; $display("FAIL start_busy got %b/%b want 1/110", busy, tm_stb); end
        wait_done(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL refresh_done got timeout want done"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_done got %b want 1", busy); end
        checks++; if (keys !== exp_keys()) begin errors++; $display("FAIL keys got %h want %h", keys, exp_keys()); end
        checks++; if (keys[31:0] !== 32'h80100001) begin errors++; $display("FAIL keys_b0 got %h want 80100001", keys[31:0]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", busy); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
        d = txn_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL traffic idx %0d got %0d txns want %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bus_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_display_off();
        bit ok;
        int d;
        logic [2:0] lvl;
        rand_setup();
        lvl = 3'($urandom_range(0, 7));
        display_on = 1'b0;
        display_level = lvl;
        for (int b = 0; b < NB; b++) model_board(b, seg_data[b*128 +: 128], 1'b0, lvl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL off_done got timeout want done"); end
        checks++; if (got_q.size() > 2 && got_q[2].data[7:0] !== 8'h80) begin errors++; $display("FAIL off_ctrl got %h want 80", got_q[2].data[7:0]); end
        d = txn_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL off_traffic idx %0d got %0d want %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (keys !== exp_keys()) begin errors++; $display("FAIL off_keys got %h want %h", keys, exp_keys()); end
        display_on = 1'b1;
    endtask

    task automatic test_capture();
        bit ok;
        int d;
        logic [NB*128-1:0] seg_a;
        logic [2:0] lvl_a, lvl_b;
        rand_setup();
        seg_a = seg_data;
        lvl_a = 3'($urandom_range(0, 7));
        lvl_b = 3'($urandom_range(0, 7));
        display_on = 1'b1;
        display_level = lvl_a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < NB*4; i++) seg_data[i*32 +: 32] = $urandom();
        display_level = lvl_b;
        display_on = 1'b0;
        model_board(0, seg_a[127:0], 1'b1, lvl_a);
        for (int b = 1; b < NB; b++) model_board(b, seg_data[b*128 +: 128], 1'b0, lvl_b);
        wait_done(6000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL cap_done got timeout want done"); end
        d = txn_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL cap_traffic idx %0d got %0d want %0d", d, got_q.size(), exp_q.size()); end
        display_on = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int d;
        rand_setup();
        display_level = 3'd2;
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < NB; b++) model_board(b, seg_data[b*128 +: 128], 1'b1, 3'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6000, ok1);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || tm_stb !== 3'b110) begin errors++; $display("FAIL pend_restart got %b/%b want 1/110", busy, tm_stb); end
        wait_done(6000, ok2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || tm_stb !== 3'b110) begin errors++; $display("FAIL start_at_done got %b/%b want 1/110", busy, tm_stb); end
        for (int b = 0; b < NB; b++) model_board(b, seg_data[b*128 +: 128], 1'b1, 3'd2);
        wait_done(6000, ok3);
        repeat (3000) @(negedge clk);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_done got %b%b%b want 111", ok1, ok2, ok3); end
        checks++; if (done_cnt !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", done_cnt); end
        d = txn_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL b2b_traffic idx %0d got %0d want %0d", d, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        logic [NB*32-1:0] old_keys;
        rand_setup();
        old_keys = keys;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (got_q.size() == 1 && cur.nbits > 24) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_reach got timeout want W_DATA"); end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || tm_stb !== '1 || tm_clk !== 1'b1) begin errors++; $display("FAIL async_rst got %b/%b/%b want 0/111/1", busy, tm_stb, tm_clk); end
        checks++; if (keys !== '0 || tm_dio_oe !== 1'b1 || tm_dio_o !== 1'b1) begin errors++; $display("FAIL async_rst2 got %h/%b/%b want 0/1/1", keys, tm_dio_oe, tm_dio_o); end
        checks++; if (done_cnt !== 0 || old_keys === 'x) begin errors++; $display("FAIL mid_kv got %0d want 0", done_cnt); end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        got_q.delete();
        repeat (3000) @(negedge clk);
        checks++; if (got_q.size() !== 0 || done_cnt !== 0) begin errors++; $display("FAIL post_rst_idle got %0d txns %0d done want 0 0", got_q.size(), done_cnt); end
        for (int b = 0; b < NB; b++) model_board(b, seg_data[b*128 +: 128], display_on, display_level);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || keys !== exp_keys()) begin errors++; $display("FAIL fresh_keys got %h want %h", keys, exp_keys()); end
        d = txn_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL fresh_traffic idx %0d got %0d want %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rst_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_idle();
        got_q.delete();
        done_cnt = 0;
        repeat (4500) @(negedge clk);
`ifdef TM1638_AUTO_REFRESH_EN
        checks++; if (done_cnt < 1) begin errors++; $display("FAIL auto_refresh got %0d done want >=1", done_cnt); end
`else
        checks++; if (got_q.size() !== 0 || done_cnt !== 0) begin errors++; $display("FAIL idle_bus got %0d txns want 0", got_q.size()); end
        checks++; if (tm_stb !== '1 || busy !== 1'b0) begin errors++; $display("FAIL idle_state got %b/%b want 111/0", tm_stb, busy); end
`endif
    endtask

    initial begin
        for (int b = 0; b < NB; b++) rd_word[b] = '0;
        test_reset();
        test_refresh();
        test_display_off();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
